// File: rtl/mes_mtx_multi_pkg.sv
// Shared types for the multi-channel time-interval meter: FSM states, mode codes
// and the mode decoder that folds the spare code onto period measurement.
package mes_mtx_multi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_MEAS = 2'd2
  } state_e;

  localparam logic [1:0] MODE_PER = 2'b00;
  localparam logic [1:0] MODE_FRQ = 2'b01;
  localparam logic [1:0] MODE_WID = 2'b10;

  typedef enum logic [1:0] {
    KIND_PER = 2'd0,
    KIND_FRQ = 2'd1,
    KIND_WID = 2'd2
  } kind_e;

  // Code 11 is not a separate measurement; it behaves exactly like period.
  function automatic kind_e decode_mode(input logic [1:0] mode);
    case (mode)
      MODE_FRQ: return KIND_FRQ;
      MODE_WID: return KIND_WID;
      default:  return KIND_PER;
    endcase
  endfunction

endpackage

// File: rtl/mes_mtx_multi_sync_edge_det.sv
// Two-flop synchroniser for one asynchronous input, plus rise/fall pulses taken
// from the synchronised level against its one-cycle-delayed copy.
module mes_mtx_multi_sync_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic s3_q, s3_d;

  always_comb begin
    s1_d = din;
    s2_d = s1_q;
    s3_d = s2_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

  assign level = s2_q;
  assign rise  = s2_q & ~s3_q;
  assign fall  = ~s2_q & s3_q;

endmodule

// File: rtl/mes_mtx_multi.sv
// Multi-channel time-interval meter: period, frequency or high-pulse width of the
// selected asynchronous input, counted in ce ticks and published with valid/ovf.
module mes_mtx_multi
  import mes_mtx_multi_pkg::*;
#(
  parameter int NCH        = 4,
  parameter int W          = 16,
  parameter int GATE_TICKS = 10000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ce,
  input  logic [NCH-1:0]           mtx,
  input  logic [$clog2(NCH)-1:0]   sel,
  input  logic [1:0]               mode,
  input  logic                     hold,
  output logic [W-1:0]             result,
  output logic                     valid,
  output logic                     ovf,
  output logic                     front,
  output logic                     busy
);

  localparam int             SW       = $clog2(NCH);
  localparam int             GW       = $clog2(GATE_TICKS + 1);
  localparam logic [W-1:0]   CNT_MAX  = '1;
  localparam logic [GW-1:0]  GATE_END = GW'(GATE_TICKS);

  logic [NCH-1:0] lvl_v, rise_v, fall_v;

  for (genvar g = 0; g < NCH; g++) begin : g_det
    mes_mtx_multi_sync_edge_det u_det (
      .clk   (clk),
      .rst   (rst),
      .din   (mtx[g]),
      .level (lvl_v[g]),
      .rise  (rise_v[g]),
      .fall  (fall_v[g])
    );
  end

  logic lvl_sel, rise_sel, fall_sel;
  assign lvl_sel  = lvl_v[sel];
  assign rise_sel = rise_v[sel];
  assign fall_sel = fall_v[sel];

  state_e          state_q, state_d;
  logic [W-1:0]    cnt_q, cnt_d;
  logic [W-1:0]    ecnt_q, ecnt_d;
  logic [GW-1:0]   gate_q, gate_d;
  logic [W-1:0]    result_q, result_d;
  logic            valid_q, valid_d;
  logic            ovf_q, ovf_d;
  logic            front_q, front_d;
  logic [SW-1:0]   sel_prev_q, sel_prev_d;
  logic [1:0]      mode_prev_q, mode_prev_d;

  kind_e           kind;
  logic            chg;
  logic            cnt_add;
  logic            close_evt;
  logic [W:0]      cnt_inc;
  logic [W:0]      ecnt_inc;
  logic [W-1:0]    ecnt_sat;
  logic [GW-1:0]   gate_inc;
  logic            cnt_top;
  logic            gate_end;
  logic            pub;
  logic [W-1:0]    pub_val;
  logic            pub_ovf;

  assign kind = decode_mode(mode);
  assign chg  = (sel != sel_prev_q) || (mode != mode_prev_q);

  // Width counts only high time; the fall cycle itself closes the interval,
  // so its tick belongs to the pulse just like the closing tick of a period.
  assign cnt_add   = (kind == KIND_WID) ? (ce & (lvl_sel | fall_sel)) : ce;
  assign close_evt = (kind == KIND_WID) ? fall_sel : rise_sel;

  assign cnt_inc  = {1'b0, cnt_q} + (W+1)'(cnt_add);
  assign cnt_top  = (cnt_inc >= {1'b0, CNT_MAX});
  assign ecnt_inc = {1'b0, ecnt_q} + (W+1)'(rise_sel);
  assign ecnt_sat = ecnt_inc[W] ? CNT_MAX : ecnt_inc[W-1:0];
  assign gate_inc = gate_q + GW'(ce);
  assign gate_end = ce && (gate_inc == GATE_END);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: state_d = ST_ARM;
      ST_ARM: begin
        if ((kind == KIND_FRQ) || rise_sel) state_d = ST_MEAS;
      end
      ST_MEAS: begin
        if ((kind != KIND_FRQ) && (cnt_top || (close_evt && (kind == KIND_WID))))
          state_d = ST_ARM;
      end
      default: state_d = ST_IDLE;
    endcase
    if (chg) state_d = ST_ARM;
  end

  // Counters run only in MEAS; everywhere else they sit at zero so a new
  // measurement always starts clean.
  always_comb begin
    cnt_d   = cnt_q;
    ecnt_d  = ecnt_q;
    gate_d  = gate_q;
    pub     = 1'b0;
    pub_val = '0;
    pub_ovf = 1'b0;
    if (state_q == ST_MEAS) begin
      if (kind == KIND_FRQ) begin
        gate_d = gate_inc;
        ecnt_d = ecnt_sat;
        if (gate_end) begin
          pub     = 1'b1;
          pub_val = ecnt_sat;
          pub_ovf = (ecnt_inc >= {1'b0, CNT_MAX});
          gate_d  = '0;
          ecnt_d  = '0;
        end
      end else begin
        cnt_d = cnt_inc[W-1:0];
        if (cnt_top) begin
          pub     = 1'b1;
          pub_val = CNT_MAX;
          pub_ovf = 1'b1;
          cnt_d   = '0;
        end else if (close_evt) begin
          pub     = 1'b1;
          pub_val = cnt_inc[W-1:0];
          cnt_d   = '0;
        end
      end
    end else begin
      cnt_d  = '0;
      ecnt_d = '0;
      gate_d = '0;
    end
    if (chg) begin
      pub    = 1'b0;
      cnt_d  = '0;
      ecnt_d = '0;
      gate_d = '0;
    end
  end

  always_comb begin
    valid_d     = pub & ~hold;
    result_d    = valid_d ? pub_val : result_q;
    ovf_d       = valid_d ? pub_ovf : ovf_q;
    front_d     = rise_sel;
    sel_prev_d  = sel;
    mode_prev_d = mode;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      ecnt_q      <= '0;
      gate_q      <= '0;
      result_q    <= '0;
      valid_q     <= 1'b0;
      ovf_q       <= 1'b0;
      front_q     <= 1'b0;
      sel_prev_q  <= '0;
      mode_prev_q <= '0;
    end else begin
      cnt_q       <= cnt_d;
      ecnt_q      <= ecnt_d;
      gate_q      <= gate_d;
      result_q    <= result_d;
      valid_q     <= valid_d;
      ovf_q       <= ovf_d;
      front_q     <= front_d;
      sel_prev_q  <= sel_prev_d;
      mode_prev_q <= mode_prev_d;
    end
  end

  assign result = result_q;
  assign valid  = valid_q;
  assign ovf    = ovf_q;
  assign front  = front_q;
  assign busy   = (state_q == ST_ARM) || (state_q == ST_MEAS);

endmodule

// File: tb/tb_mes_mtx_multi.sv
// Directed-random bench for mes_mtx_multi: square waves whose periods are whole
// multiples of the ce spacing, so every expected count follows from plain division.
module tb_mes_mtx_multi;

  localparam int NCH   = 4;
  localparam int W     = 8;
  localparam int GATE  = 100;
  localparam int CEDIV = 4;

  logic         clk;
  logic         rst;
  logic         ce;
  logic [3:0]   mtx;
  logic [1:0]   sel;
  logic [1:0]   mode;
  logic         hold;
  logic [W-1:0] result;
  logic         valid;
  logic         ovf;
  logic         front;
  logic         busy;

  mes_mtx_multi #(.NCH(NCH), .W(W), .GATE_TICKS(GATE)) dut (
    .clk    (clk),
    .rst    (rst),
    .ce     (ce),
    .mtx    (mtx),
    .sel    (sel),
    .mode   (mode),
    .hold   (hold),
    .result (result),
    .valid  (valid),
    .ovf    (ovf),
    .front  (front),
    .busy   (busy)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int per_clk[4];
  int hi_clk[4];
  int last_rise[4];
  int front_lat = -1;
  int vres[$];
  int vovf[$];
  int vcyc[$];
  int vfront[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    int div = 0;
    ce = 1'b0;
    forever begin
      @(negedge clk);
      ce = (div == 0);
      div = (div == CEDIV - 1) ? 0 : div + 1;
    end
  end

  // Square-wave sources; a change of period restarts the wave with a rising edge.
  initial begin
    int ph[4];
    int last_per[4];
    for (int c = 0; c < 4; c++) begin
      ph[c] = 0;
      last_per[c] = 0;
      last_rise[c] = 0;
    end
    mtx = '0;
    forever begin
      @(negedge clk);
      for (int c = 0; c < 4; c++) begin
        if (per_clk[c] != last_per[c]) begin
          ph[c] = 0;
          last_per[c] = per_clk[c];
        end
        if (per_clk[c] == 0) begin
          mtx[c] = 1'b0;
        end else begin
          if ((ph[c] < hi_clk[c]) && !mtx[c]) last_rise[c] = cyc;
          mtx[c] = (ph[c] < hi_clk[c]);
          ph[c] = (ph[c] + 1 >= per_clk[c]) ? 0 : ph[c] + 1;
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (front) front_lat = cyc - last_rise[sel];
    if (valid) begin
      vres.push_back(int'(result));
      vovf.push_back(int'(ovf));
      vcyc.push_back(cyc);
      vfront.push_back(int'(front));
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_valids(input int base, input int n, input int budget);
    int k = 0;
    while ((vres.size() < base + n) && (k < budget)) begin
      @(negedge clk);
      k++;
    end
    check_output("valid_arrival", int'(vres.size() >= base + n), 1);
  endtask

  task automatic set_wave(input int ch, input int per, input int hi);
    per_clk[ch] = per;
    hi_clk[ch]  = hi;
  endtask

  initial begin
    int base, r, p, q, a, b, expv, idx;
    int qlist[6];
    qlist[0] = 8; qlist[1] = 10; qlist[2] = 16;
    qlist[3] = 20; qlist[4] = 40; qlist[5] = 50;
    for (int c = 0; c < 4; c++) set_wave(c, 0, 0);

    rst = 1'b1; sel = 2'd0; mode = 2'b00; hold = 1'b0;
    repeat (3) @(negedge clk);
    check_output("rst_result", int'(result), 0);
    check_output("rst_valid", int'(valid), 0);
    check_output("rst_ovf", int'(ovf), 0);
    check_output("rst_front", int'(front), 0);
    check_output("rst_busy", int'(busy), 0);
    rst = 1'b0;
    @(negedge clk);
    check_output("arm_after_rst", int'(busy), 1);

    // Period: result is the period in ce ticks; the first interval after a
    // waveform restart without abort is skipped.
    for (int it = 0; it < 2; it++) begin
      r = $urandom_range(3, 20);
      p = r * CEDIV;
      sel = 2'd1; mode = 2'b00;
      set_wave(1, p, p / 2);
      base = vres.size();
      wait_valids(base, 4, 5 * p + 100);
      for (int i = 1; i < 4; i++) begin
        check_output("period_result", vres[base+i], r);
        check_output("period_ovf", vovf[base+i], 0);
      end
      check_output("period_spacing", vcyc[base+3] - vcyc[base+2], p);
      check_output("period_front_with_valid", vfront[base+2], 1);
      check_output("front_latency", front_lat, 3);
    end

    // Frequency: rises per gate of GATE ce ticks.
    idx = $urandom_range(0, 5);
    q = qlist[idx];
    expv = (GATE * CEDIV) / q;
    sel = 2'd2; mode = 2'b01;
    set_wave(2, q, q / 2);
    base = vres.size();
    wait_valids(base, 3, 3 * GATE * CEDIV + 200);
    check_output("freq_first_pm1", int'((vres[base] >= expv - 1) && (vres[base] <= expv + 1)), 1);
    check_output("freq_result1", vres[base+1], expv);
    check_output("freq_result2", vres[base+2], expv);
    check_output("freq_spacing", vcyc[base+2] - vcyc[base+1], GATE * CEDIV);

    // High-pulse width.
    a = $urandom_range(6, 15);
    b = $urandom_range(2, a - 2);
    sel = 2'd1; mode = 2'b10;
    set_wave(1, a * CEDIV, b * CEDIV);
    base = vres.size();
    wait_valids(base, 3, 4 * a * CEDIV + 100);
    for (int i = 0; i < 3; i++) check_output("width_result", vres[base+i], b);
    check_output("width_spacing", vcyc[base+2] - vcyc[base+1], a * CEDIV);

    // Timeout: one rise then the input stays low.
    sel = 2'd0; mode = 2'b00;
    set_wave(0, 100000, 8);
    base = vres.size();
    wait_valids(base, 1, 2000);
    check_output("timeout_result", vres[base], 255);
    check_output("timeout_ovf", vovf[base], 1);
    @(negedge clk);
    check_output("timeout_rearm_busy", int'(busy), 1);
    set_wave(0, 0, 0);

    // Abort: switching channel mid-period drops the pending measurement.
    sel = 2'd1; mode = 2'b00;
    set_wave(1, 40, 20);
    set_wave(3, 28, 14);
    base = vres.size();
    wait_valids(base, 2, 200);
    check_output("abort_pre_result", vres[base+1], 10);
    repeat (15) @(negedge clk);
    sel = 2'd3;
    base = vres.size();
    repeat (2) @(negedge clk);
    check_output("abort_result_kept", int'(result), 10);
    check_output("abort_ovf_kept", int'(ovf), 0);
    check_output("abort_no_valid", vres.size() - base, 0);
    wait_valids(base, 1, 200);
    check_output("abort_first_new", vres[base], 7);

    // Hold freezes the published value while measurement continues.
    hold = 1'b1;
    set_wave(3, 36, 18);
    base = vres.size();
    repeat (200) @(negedge clk);
    check_output("hold_no_valid", vres.size() - base, 0);
    check_output("hold_result", int'(result), 7);
    hold = 1'b0;
    wait_valids(base, 1, 200);
    check_output("hold_release_result", vres[base], 9);

    // Reset mid-measurement.
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_output("midrst_result", int'(result), 0);
    check_output("midrst_busy", int'(busy), 0);
    check_output("midrst_ovf", int'(ovf), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_output("midrst_arm", int'(busy), 1);
    base = vres.size();
    wait_valids(base, 2, 200);
    check_output("midrst_resume", vres[base+1], 9);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
